// File: rtl/digit_serial_cla_adder_pkg.sv
// Shared constants for the digit-serial adder: FSM encoding, digit width and
// the counter sizing rule.
package digit_serial_cla_adder_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A single-digit adder still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_bits(input int width);
        int n_dig;
        n_dig = width / DIGIT_W;
        return (n_dig > 1) ? $clog2(n_dig) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_cla_adder_nibble_cla.sv
// Combinational 4-bit carry-lookahead slice. Every carry is a flat
// generate/propagate sum of products, so no carry ripples between bits.
module nibble_cla_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

endmodule

// File: rtl/digit_serial_cla_adder.sv
// Multi-cycle adder: one 4-bit digit per clock through a single CLA slice,
// with valid/ready handshakes on both the operand and the result side.
module digit_serial_cla_adder
    import digit_serial_cla_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    generate
        if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_width
            $error("digit_serial_cla_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               carry_q,  carry_d;
    logic               cout_q,   cout_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;

    logic [DIGIT_W-1:0] slice_s;
    logic               slice_cout;

    nibble_cla_cin u_slice (
        .a    (a_sr_q[DIGIT_W-1:0]),
        .b    (b_sr_q[DIGIT_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Each new digit enters at the MSB end, so after NDIG shifts digit 0 sits at the LSBs.
                sum_sr_d = (sum_sr_q >> DIGIT_W) | (WIDTH'(slice_s) << (WIDTH - DIGIT_W));
                a_sr_d   = a_sr_q >> DIGIT_W;
                b_sr_d   = b_sr_q >> DIGIT_W;
                carry_d  = slice_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cout_d  = slice_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !reset;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign sum       = sum_sr_q;
    assign cout      = cout_q;

endmodule
